// File: rtl/serving_wb_loader.sv
// Wishbone initiator that bulk-loads RAM from a byte stream or dumps RAM to one.
// Load packs bytes little-endian into words; dump splits read words into bytes.
module serving_wb_loader #(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_dir,
  input  logic [aw-3:0] i_base,
  input  logic [aw:0]   i_len,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [aw:0]   len_one = (aw+1)'(1);
  localparam logic [aw-3:0] adr_one = (aw-2)'(1);

  state_t        state;
  state_t        next;
  logic [aw-3:0] adr;
  logic [aw:0]   remaining;
  logic [1:0]    lane;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic [31:0]   rdat;
  logic          last_byte;
  logic          word_end;

  assign last_byte = (remaining == len_one);
  assign word_end  = (lane == 2'd3) || last_byte;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_len == '0)  next = DONE;
          else if (i_dir)   next = READ;
          else              next = FILL;
        end else begin
          next = IDLE;
        end
      end
      FILL: begin
        if (i_rx_valid && word_end) next = WRITE;
        else                        next = FILL;
      end
      WRITE: begin
        if (i_wb_ack) next = (remaining == '0) ? DONE : FILL;
        else          next = WRITE;
      end
      READ: begin
        if (i_wb_ack) next = DRAIN;
        else          next = READ;
      end
      DRAIN: begin
        if (i_tx_ready && word_end) next = last_byte ? DONE : READ;
        else                        next = DRAIN;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Address, byte counter, lane index and word buffers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr       <= '0;
      remaining <= '0;
      lane      <= 2'd0;
      dat       <= 32'h0;
      sel       <= 4'h0;
      rdat      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            adr       <= i_base;
            remaining <= i_len;
            lane      <= 2'd0;
            sel       <= 4'h0;
          end
        end
        FILL: begin
          if (i_rx_valid) begin
            dat[{lane, 3'b000} +: 8] <= i_rx_data;
            sel[lane]                <= 1'b1;
            remaining                <= remaining - len_one;
            lane                     <= lane + 2'd1;
          end
        end
        WRITE: begin
          if (i_wb_ack) begin
            adr  <= adr + adr_one;
            lane <= 2'd0;
            sel  <= 4'h0;
          end
        end
        READ: begin
          if (i_wb_ack) begin
            rdat <= i_wb_rdt;
            lane <= 2'd0;
          end
        end
        DRAIN: begin
          if (i_tx_ready) begin
            remaining <= remaining - len_one;
            lane      <= lane + 2'd1;
            // Address wraps naturally at the top of RAM
            if (word_end) adr <= adr + adr_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    o_rx_ready = 1'b0;
    o_tx_valid = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_sel   = 4'h0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      FILL: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
      end
      WRITE: begin
        o_wb_stb = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_sel = sel;
        o_busy   = 1'b1;
      end
      READ: begin
        o_wb_stb = 1'b1;
        o_wb_sel = 4'hF;
        o_busy   = 1'b1;
      end
      DRAIN: begin
        o_tx_valid = 1'b1;
        o_busy     = 1'b1;
      end
      DONE:    o_done = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  assign o_wb_adr  = adr;
  assign o_wb_dat  = dat;
  assign o_tx_data = rdat[{lane, 3'b000} +: 8];

endmodule
